// File: rtl/bitcount_arbiter.sv
// Round-robin scheduler sharing one bitcount engine among N valid/ready requesters.
// Latency is accept -> start 1 cycle, finish -> resp_valid 2 cycles, and a watchdog aborts after TIMEOUT RUN cycles. A stalled resp_ready freezes the response and holds all req_ready low.
module bitcount_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*32-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_count,
    output logic              resp_err,
    output logic              busy,
    output logic              eng_start,
    output logic [31:0]       eng_in,
    output logic              eng_rst,
    input  logic              eng_finish,
    input  logic [31:0]       eng_count
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [31:0]      op_q, op_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic [31:0]      rcount_q, rcount_d;
    logic [IDW-1:0]   rid_q, rid_d;
    logic             rerr_q, rerr_d;
    logic             eng_rst_q, eng_rst_d;

    logic             found;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   cand;
    logic [31:0]      grant_data;
    logic [N-1:0]     ready_c;

    // Scan last+1, last+2, ... so the most recent winner has lowest priority.
    always_comb begin
        found = 1'b0;
        grant = last_q;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDW'((int'(last_q) + i) % N);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == IDW'(k)) grant_data = req_data[k*32 +: 32];
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        op_d      = op_q;
        wd_d      = wd_q;
        rcount_d  = rcount_q;
        rid_d     = rid_q;
        rerr_d    = rerr_q;
        eng_rst_d = 1'b0;
        ready_c   = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ready_c[grant] = 1'b1;
                    op_d    = grant_data;
                    id_d    = grant;
                    last_d  = grant;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + WDW'(1);
                // wd_q == 0 marks the first RUN cycle, where finish may still be stale.
                if (wd_q != '0 && eng_finish) begin
                    state_d = S_CAPTURE;
                end else if (wd_q + WDW'(1) == WD_LIMIT) begin
                    eng_rst_d = 1'b1;
                    rid_d     = id_q;
                    rcount_d  = '0;
                    rerr_d    = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_CAPTURE: begin
                rcount_d = eng_count;
                rid_d    = id_q;
                rerr_d   = 1'b0;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= IDW'(N - 1);
            id_q      <= '0;
            op_q      <= '0;
            wd_q      <= '0;
            rcount_q  <= '0;
            rid_q     <= '0;
            rerr_q    <= 1'b0;
            eng_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            op_q      <= op_d;
            wd_q      <= wd_d;
            rcount_q  <= rcount_d;
            rid_q     <= rid_d;
            rerr_q    <= rerr_d;
            eng_rst_q <= eng_rst_d;
        end
    end

    // Gated by rst so a held reset never advertises readiness.
    assign req_ready  = rst ? '0 : ready_c;
    assign resp_valid = (state_q == S_RESP);
    assign resp_id    = rid_q;
    assign resp_count = rcount_q;
    assign resp_err   = rerr_q;
    assign busy       = (state_q != S_IDLE);
    assign eng_start  = (state_q == S_LAUNCH);
    assign eng_in     = (state_q == S_LAUNCH || state_q == S_RUN || state_q == S_CAPTURE) ? op_q : 32'd0;
    assign eng_rst    = eng_rst_q;

endmodule
